otter_load_store_unit: RTL and testbench

//  Data-side initiator for the OTTER memory port 2 (RDEN2/WE2/ADDR2/DIN2/SIZE/SIGN -> DOUT2).

---
 rtl/otter_load_store_unit.sv | 133 +++++++++++++
 tb/tb_otter_load_store_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_load_store_unit.sv
// Load/store initiator for OTTER memory port 2.
// Accepts one request at a time, screens it for alignment, runs the
// single-cycle BRAM/MMIO strobe, and returns data or an acknowledge.
module otter_load_store_unit #(
    parameter bit          CHECK_ALIGN = 1'b1,
    parameter logic [31:0] IO_BASE     = 32'h00010000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_sign_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_io_o,
    output logic        mem_rden2_o,
    output logic        mem_we2_o,
    output logic [31:0] mem_addr2_o,
    output logic [31:0] mem_din2_o,
    output logic [1:0]  mem_size_o,
    output logic        mem_sign_o,
    input  logic [31:0] mem_dout2_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        err_q, err_d;
    logic        io_q, io_d;
    logic [31:0] rdata_q, rdata_d;

    // Size 3 is never legal; halves need an even address, words a 4-byte one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return (a != 2'd0);
            default: return 1'b1;
        endcase
    endfunction

    // State and request/response registers; reset drops strobes immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            io_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
            io_q    <= io_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic; request fields only change when a request is accepted in IDLE.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        err_d   = err_q;
        io_d    = io_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    size_d  = req_size_i;
                    sign_d  = req_sign_i;
                    err_d   = CHECK_ALIGN && is_misaligned(req_size_i, req_addr_i[1:0]);
                    io_d    = (req_addr_i >= IO_BASE);
                    rdata_d = '0;
                    state_d = (CHECK_ALIGN && is_misaligned(req_size_i, req_addr_i[1:0]))
                              ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_d = we_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                rdata_d = mem_dout2_i;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from registers or state decode.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
        mem_rden2_o = (state_q == ACCESS) && !we_q;
        mem_we2_o   = (state_q == ACCESS) && we_q;
        mem_addr2_o = addr_q;
        mem_din2_o  = wdata_q;
        mem_size_o  = size_q;
        mem_sign_o  = sign_q;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
        rsp_io_o    = io_q;
    end

endmodule

// File: tb/tb_otter_load_store_unit.sv
// Directed bench for otter_load_store_unit with a small BRAM/MMIO model.
module tb_otter_load_store_unit;

    localparam logic [31:0] IO_BASE = 32'h00010000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_sign = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_io;
    logic        mem_rden2;
    logic        mem_we2;
    logic [31:0] mem_addr2;
    logic [31:0] mem_din2;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_dout2 = '0;

    otter_load_store_unit #(.CHECK_ALIGN(1'b1), .IO_BASE(IO_BASE)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_size_i(req_size), .req_sign_i(req_sign),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_io_o(rsp_io),
        .mem_rden2_o(mem_rden2), .mem_we2_o(mem_we2), .mem_addr2_o(mem_addr2),
        .mem_din2_o(mem_din2), .mem_size_o(mem_size), .mem_sign_o(mem_sign),
        .mem_dout2_i(mem_dout2)
    );

    always #5 clk = ~clk;

    // Memory model: word array below IO_BASE, a single input register above it.
    logic [31:0] mem [0:255];
    logic [31:0] io_in = 32'h0;
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          rd_pulses = 0, we_pulses = 0, both_pulses = 0;
    logic [31:0] last_we_din = '0;
    logic [1:0]  last_we_size = '0;

    function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr[9:2]] <= pl_data;
        if (mem_rden2) begin
            rd_pulses <= rd_pulses + 1;
            mem_dout2 <= mem_read((mem_addr2 >= IO_BASE) ? io_in : mem[mem_addr2[9:2]],
                                  mem_addr2[1:0], mem_size, mem_sign);
        end
        if (mem_we2) begin
            we_pulses    <= we_pulses + 1;
            last_we_din  <= mem_din2;
            last_we_size <= mem_size;
            if (mem_addr2 < IO_BASE) begin
                case (mem_size)
                    2'd0:    mem[mem_addr2[9:2]][8*mem_addr2[1:0] +: 8] <= mem_din2[7:0];
                    2'd1:    mem[mem_addr2[9:2]][16*mem_addr2[1] +: 16] <= mem_din2[15:0];
                    default: mem[mem_addr2[9:2]] <= mem_din2;
                endcase
            end
        end
        if (mem_rden2 && mem_we2) both_pulses <= both_pulses + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Results of the most recent transaction.
    logic [31:0] r_rdata;
    logic        r_err, r_io;
    int          r_lat, r_rd, r_we;

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic sg, input int hold);
        int rd0, we0;
        @(negedge clk);
        rd0 = rd_pulses; we0 = we_pulses;
        req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_sign = sg;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_lat = 1;
        while (!rsp_valid && r_lat < 10) begin
            @(posedge clk); #1;
            r_lat++;
        end
        r_rdata = rsp_rdata; r_err = rsp_err; r_io = rsp_io;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_addr = 32'h0000_0300; req_we = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
            chk("hold_rdata", rsp_rdata, r_rdata);
            chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        r_rd = rd_pulses - rd0;
        r_we = we_pulses - we0;
    endtask

    initial begin
        #12;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_strobes", {30'h0, mem_rden2, mem_we2}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_addr2", mem_addr2, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Word load
        preload(32'h100, 32'hDEADBEEF);
        do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0);
        chk("lw_rdata", r_rdata, 32'hDEADBEEF);
        chk("lw_err", {31'h0, r_err}, 32'h0);
        chk("lw_io", {31'h0, r_io}, 32'h0);
        chk("lw_lat", r_lat, 3);
        chk("lw_rden", r_rd, 1);
        chk("lw_we", r_we, 0);
        chk("lw_ready_after", {31'h0, req_ready}, 32'h1);

        // Byte loads, signed and unsigned
        preload(32'h100, 32'h80000000);
        do_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 0);
        chk("lb_signed", r_rdata, 32'hFFFFFF80);
        do_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 0);
        chk("lbu", r_rdata, 32'h00000080);

        // Half store then word readback
        preload(32'h200, 32'h0);
        do_req(1'b1, 32'h202, 32'h1234, 2'd1, 1'b0, 0);
        chk("sh_lat", r_lat, 2);
        chk("sh_we", r_we, 1);
        chk("sh_rden", r_rd, 0);
        chk("sh_din", last_we_din, 32'h1234);
        chk("sh_size", {30'h0, last_we_size}, 32'h1);
        chk("sh_rdata", r_rdata, 32'h0);
        do_req(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 0);
        chk("sh_readback", r_rdata, 32'h12340000);

        // Misaligned word load
        do_req(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 0);
        chk("mis_err", {31'h0, r_err}, 32'h1);
        chk("mis_rdata", r_rdata, 32'h0);
        chk("mis_lat", r_lat, 1);
        chk("mis_strobes", r_rd + r_we, 0);

        // Illegal size and odd half
        do_req(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 0);
        chk("size3_err", {31'h0, r_err}, 32'h1);
        do_req(1'b1, 32'h201, 32'h5555, 2'd1, 1'b0, 0);
        chk("odd_half_err", {31'h0, r_err}, 32'h1);
        chk("odd_half_we", r_we, 0);

        // MMIO
        io_in = 32'hA5A5A5A5;
        do_req(1'b0, 32'h11000000, 32'h0, 2'd2, 1'b0, 0);
        chk("io_rdata", r_rdata, 32'hA5A5A5A5);
        chk("io_flag", {31'h0, r_io}, 32'h1);
        do_req(1'b1, 32'h11000000, 32'h77, 2'd2, 1'b0, 0);
        chk("io_store_flag", {31'h0, r_io}, 32'h1);
        chk("io_store_lat", r_lat, 2);
        do_req(1'b0, 32'hFFFFFFFC, 32'h0, 2'd2, 1'b0, 0);
        chk("top_rdata", r_rdata, 32'hA5A5A5A5);
        chk("top_err", {31'h0, r_err}, 32'h0);
        chk("top_io", {31'h0, r_io}, 32'h1);
        do_req(1'b0, 32'h00010002, 32'h0, 2'd2, 1'b0, 0);
        chk("io_err_flag", {31'h0, r_io}, 32'h1);
        chk("io_err", {31'h0, r_err}, 32'h1);

        // Response backpressure with a request waiting
        do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 5);
        chk("bp_rdata", r_rdata, 32'h80000000);
        chk("bp_rden", r_rd, 1);
        chk("bp_idle_ready", {31'h0, req_ready}, 32'h1);
        chk("bp_no_rsp", {31'h0, rsp_valid}, 32'h0);

        // Reset while in ACCESS
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_sign = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("acc_rden", {31'h0, mem_rden2}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_strobe", {31'h0, mem_rden2}, 32'h0);
        chk("arst_ready", {31'h0, req_ready}, 32'h1);
        chk("arst_rdata", rsp_rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("never_both", both_pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
